ifetch_queue: RTL

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Purpose:
//   Instruction-fetch front end. It accepts fetch addresses from the PC
//   register, issues one instruction-memory read at a time, and queues the
//   returned {pc, instruction} pairs in a small FIFO for the decode stage.
//   A redirect (taken branch/jump) flushes the FIFO and discards any read
//   still in flight.
//
// Ports:
//   CLK         in   1   rising-edge clock for all state
//   reset       in   1   synchronous active-low reset
//   pc_in       in  32   fetch address
//   pc_valid    in   1   pc_in holds a fetch request
//   pc_ready    out  1   fetch request accepted this cycle
//   redirect    in   1   flush queued and in-flight fetches
//   imem_req    out  1   instruction-memory read request
//   imem_addr   out 32   instruction-memory address (stable while imem_req)
//   imem_ack    in   1   imem_rdata valid, completes the request
//   imem_rdata  in  32   instruction word from memory
//   inst_valid  out  1   inst / inst_pc hold the FIFO head
//   inst        out 32   instruction word at the head
//   inst_pc     out 32   fetch address of inst
//   inst_ready  in   1   decode consumes the head this cycle
//
// Parameter:
//   DEPTH       FIFO entries, power of 2 from 2 to 16 (default 4)
//
// Build option:
//   IFQ_BYPASS_EN  when defined, a word returning into an empty FIFO is
//                  presented on inst/inst_pc in the ack cycle itself and is
//                  only written into the FIFO if decode does not take it.
//
// FSM states:
//   state    | meaning
//   S_IDLE   | no read outstanding, may accept a new fetch
//   S_WAIT   | read outstanding, its data will be queued
//   S_DRAIN  | read outstanding, its data will be discarded (redirected)
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t        state;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic          fifo_empty;
  logic          accept;
  logic          ack_keep;
  logic          bypass_hit;
  logic          bypass_take;
  logic          push;
  logic          pop;

  assign fifo_empty = (count == '0);

  // Accepting only with a free slot is what makes FIFO overflow impossible:
  // the single outstanding read always has somewhere to land.
  assign pc_ready = reset && (state == S_IDLE) && !redirect && (count < FULL_COUNT);
  assign accept   = pc_valid && pc_ready;

  // Returning data that is still wanted (not redirected away).
  assign ack_keep = (state == S_WAIT) && imem_ack && !redirect;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit  = reset && fifo_empty && ack_keep;
  assign bypass_take = bypass_hit && inst_ready;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A word consumed straight off the memory bus never enters the FIFO.
  assign push = ack_keep && !bypass_take;
  assign pop  = !fifo_empty && inst_ready;

  assign inst_valid = !fifo_empty || bypass_hit;
  assign inst       = bypass_hit ? imem_rdata : fifo_inst[rd_ptr];
  assign inst_pc    = bypass_hit ? addr_q     : fifo_pc[rd_ptr];

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  // Fetch FSM. Reset abandons any outstanding read without draining; the
  // memory side is expected to tolerate the dropped request.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state  <= S_IDLE;
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_WAIT;
            req_q  <= 1'b1;
            addr_q <= pc_in;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            state <= S_IDLE;
            req_q <= 1'b0;
          end else if (redirect) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The ack completes the memory transaction even if another
          // redirect arrives with it, so there is nothing left to drain.
          if (imem_ack) begin
            state <= S_IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy and pointers. Redirect wins over any push/pop in its cycle.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge CLK) begin
    if (reset && !redirect && push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= addr_q;
    end
  end

endmodule
